cache_data_array: RTL and testbench

- Set-associative cache data store for the nnARM memory subsystem.
- Parametrised in ways, sets and words per line.
- CPU port: byte, halfword and word access with 1-cycle registered read.
- Line port: FSM-driven burst fill from memory and evict (write-back) to memory with ready/valid handshake. Sits between the cache controller (tags/hit logic) and the bus interface.

---
 rtl/cache_data_array_pkg.sv | 74 +++++++
 rtl/cache_data_array_if.sv | 56 +++++
 rtl/cache_data_bank.sv | 58 +++++
 rtl/cache_data_array.sv | 215 +++++++++++++++++++++
 tb/tb_cache_data_array.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_data_array_pkg.sv
// Shared definitions for the cache data array: size and line-command
// encodings, line-engine states, byte geometry and small lane helpers.
package cache_data_array_pkg;

  localparam int ByteWidth        = 8;
  localparam int ByteNumberInWord = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    LINE_NONE  = 2'b00,
    LINE_FILL  = 2'b01,
    LINE_EVICT = 2'b10,
    LINE_RSVD  = 2'b11
  } line_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_EVICT = 2'b10
  } state_e;

  // Width of a select field; a single-way cache still carries a 1-bit way.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << off;
      SIZE_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

  // Right-aligned CPU write data spread so every candidate lane carries it.
  function automatic logic [31:0] align_write(input logic [31:0] wd, input logic [1:0] size);
    case (size)
      SIZE_BYTE: align_write = {4{wd[7:0]}};
      SIZE_HALF: align_write = {2{wd[15:0]}};
      default:   align_write = wd;
    endcase
  endfunction

  // CPU read formatting: narrow reads are replicated across the word.
  function automatic logic [31:0] format_read(input logic [31:0] w, input logic [1:0] size,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      SIZE_BYTE: format_read = {4{b}};
      SIZE_HALF: format_read = {2{h}};
      default:   format_read = w;
    endcase
  endfunction

  // Even parity per byte: stored bit makes each 9-bit group XOR to zero.
  function automatic logic [3:0] byte_parity(input logic [31:0] w);
    for (int i = 0; i < ByteNumberInWord; i++) byte_parity[i] = ^w[ByteWidth*i +: ByteWidth];
  endfunction

endpackage

// File: rtl/cache_data_array_if.sv
// Controller-facing bus of the cache data array: CPU access port and
// line fill/evict port. out_ParityError exists only with CACHE_DATA_PARITY_EN.
interface cache_data_array_if
  import cache_data_array_pkg::*;
#(
  parameter int PARAM_WayNumber        = 2,
  parameter int PARAM_SetNumber        = 4,
  parameter int PARAM_WordNumberInLine = 4
) ();

  localparam int WAY_W = clog2_min1(PARAM_WayNumber);
  localparam int IDX_W = $clog2(PARAM_SetNumber);
  localparam int OFF_W = $clog2(PARAM_WordNumberInLine) + 2;

  logic             in_Req;
  logic             in_RW;
  logic [1:0]       in_Size;
  logic [WAY_W-1:0] in_Way;
  logic [IDX_W-1:0] in_Index;
  logic [OFF_W-1:0] in_Offset;
  logic [31:0]      in_WriteData;
  logic [31:0]      out_ReadData;
  logic             out_ReadValid;
  logic             out_Busy;
  logic [1:0]       in_LineCmd;
  logic [WAY_W-1:0] in_LineWay;
  logic [IDX_W-1:0] in_LineIndex;
  logic [31:0]      in_FillData;
  logic             in_FillValid;
  logic [31:0]      out_EvictData;
  logic             out_EvictValid;
  logic             in_EvictReady;
  logic             out_LineDone;
`ifdef CACHE_DATA_PARITY_EN
  logic             out_ParityError;
`endif

  modport master (
`ifdef CACHE_DATA_PARITY_EN
    input  out_ParityError,
`endif
    output in_Req, in_RW, in_Size, in_Way, in_Index, in_Offset, in_WriteData,
    output in_LineCmd, in_LineWay, in_LineIndex, in_FillData, in_FillValid, in_EvictReady,
    input  out_ReadData, out_ReadValid, out_Busy, out_EvictData, out_EvictValid, out_LineDone
  );

  modport slave (
`ifdef CACHE_DATA_PARITY_EN
    output out_ParityError,
`endif
    input  in_Req, in_RW, in_Size, in_Way, in_Index, in_Offset, in_WriteData,
    input  in_LineCmd, in_LineWay, in_LineIndex, in_FillData, in_FillValid, in_EvictReady,
    output out_ReadData, out_ReadValid, out_Busy, out_EvictData, out_EvictValid, out_LineDone
  );

endinterface

// File: rtl/cache_data_bank.sv
// One way of the cache data store: word-wide array with per-byte write
// enables and a registered read port. Storage itself is never reset.
// With CACHE_DATA_PARITY_EN an even-parity bit is kept per byte.
module cache_data_bank
  import cache_data_array_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              re,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
`ifdef CACHE_DATA_PARITY_EN
  ,
  output logic [3:0]        rparity
`endif
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write into the data array.
  always_ff @(posedge clock) begin
    for (int b = 0; b < ByteNumberInWord; b++) begin
      if (we[b]) mem[addr][ByteWidth*b +: ByteWidth] <= wdata[ByteWidth*b +: ByteWidth];
    end
  end

  // Registered read; output holds until the next read strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

`ifdef CACHE_DATA_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] wpar;

  assign wpar = byte_parity(wdata);

  // Parity bits follow the same byte enables as the data.
  always_ff @(posedge clock) begin
    for (int b = 0; b < ByteNumberInWord; b++) begin
      if (we[b]) par_mem[addr][b] <= wpar[b];
    end
  end

  // Parity read is registered alongside the data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  rparity <= '0;
    else if (re) rparity <= par_mem[addr];
  end
`endif

endmodule

// File: rtl/cache_data_array.sv
// Set-associative cache data store. CPU port: byte/half/word access with a
// one-cycle registered read. Line port: burst fill from memory and
// ready/valid evict to memory, sequenced by a small FSM.
// Optional byte parity: define CACHE_DATA_PARITY_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | CPU accesses served; line commands accepted when no req
//   ST_FILL  | writing fill words into the latched way/set
//   ST_EVICT | presenting line words to the consumer one at a time
module cache_data_array
  import cache_data_array_pkg::*;
#(
  parameter int PARAM_WayNumber        = 2,
  parameter int PARAM_SetNumber        = 4,
  parameter int PARAM_WordNumberInLine = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  cache_data_array_if.slave     bus
);

  localparam int WAYS   = PARAM_WayNumber;
  localparam int WORDS  = PARAM_WordNumberInLine;
  localparam int WAY_W  = clog2_min1(WAYS);
  localparam int IDX_W  = $clog2(PARAM_SetNumber);
  localparam int WRD_W  = $clog2(WORDS);
  localparam int OFF_W  = WRD_W + 2;
  localparam int ADDR_W = IDX_W + WRD_W;
  localparam int DEPTH  = PARAM_SetNumber * WORDS;

  state_e           state, state_n;
  logic [WRD_W-1:0] cnt, cnt_n, ev_word;
  logic             ev_valid, ev_valid_n;
  logic             done, done_n;
  logic [WAY_W-1:0] line_way, tgt_way, sel_way;
  logic [IDX_W-1:0] line_idx;

  logic             cpu_rd, cpu_wr, accept, last_word, ev_issue;
  logic             rd_valid;
  logic [1:0]       rd_size, rd_off;
  logic [31:0]      hold_data, sel_rdata, fmt_rdata;

  logic              bank_re;
  logic [3:0]        bank_we;
  logic [ADDR_W-1:0] bank_addr;
  logic [31:0]       bank_wdata;
  logic [31:0]       bank_rdata [WAYS];

  assign cpu_rd    = (state == ST_IDLE) && bus.in_Req && bus.in_RW;
  assign cpu_wr    = (state == ST_IDLE) && bus.in_Req && !bus.in_RW;
  assign accept    = (state == ST_IDLE) && !bus.in_Req &&
                     ((bus.in_LineCmd == LINE_FILL) || (bus.in_LineCmd == LINE_EVICT));
  assign last_word = (cnt == WRD_W'(WORDS - 1));
  assign ev_issue  = (state == ST_EVICT) && (!ev_valid || (bus.in_EvictReady && !last_word));
  assign ev_word   = ev_valid ? cnt + 1'b1 : cnt;

  // Line-engine state, word counter and output pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ev_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ev_valid <= ev_valid_n;
      done     <= done_n;
    end
  end

  // Next state: fill advances on each fill word, evict on each handshake.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ev_valid_n = ev_valid;
    done_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = (bus.in_LineCmd == LINE_FILL) ? ST_FILL : ST_EVICT;
          cnt_n   = '0;
        end
      end
      ST_FILL: begin
        if (bus.in_FillValid) begin
          if (last_word) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_EVICT: begin
        if (!ev_valid) begin
          ev_valid_n = 1'b1;
        end else if (bus.in_EvictReady) begin
          if (last_word) begin
            state_n    = ST_IDLE;
            cnt_n      = '0;
            ev_valid_n = 1'b0;
            done_n     = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Target of the line operation is captured when the command is taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_way <= '0;
      line_idx <= '0;
    end else if (accept) begin
      line_way <= bus.in_LineWay;
      line_idx <= bus.in_LineIndex;
    end
  end

  // Bank port steering: CPU owns it in IDLE, the line engine otherwise.
  always_comb begin
    bank_re    = 1'b0;
    bank_we    = 4'b0000;
    bank_addr  = {bus.in_Index, bus.in_Offset[OFF_W-1:2]};
    bank_wdata = align_write(bus.in_WriteData, bus.in_Size);
    tgt_way    = bus.in_Way;
    case (state)
      ST_IDLE: begin
        bank_re = cpu_rd;
        if (cpu_wr) bank_we = lane_mask(bus.in_Size, bus.in_Offset[1:0]);
      end
      ST_FILL: begin
        bank_addr  = {line_idx, cnt};
        bank_wdata = bus.in_FillData;
        bank_we    = {4{bus.in_FillValid}};
        tgt_way    = line_way;
      end
      ST_EVICT: begin
        bank_addr = {line_idx, ev_word};
        bank_re   = ev_issue;
        tgt_way   = line_way;
      end
      default: ;
    endcase
  end

`ifdef CACHE_DATA_PARITY_EN
  logic [3:0] bank_rpar [WAYS];
`endif

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic hit;
    assign hit = (tgt_way == WAY_W'(w));
    cache_data_bank #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clock   (clock),
      .reset   (reset),
      .re      (bank_re && hit),
      .we      (hit ? bank_we : 4'b0000),
      .addr    (bank_addr),
      .wdata   (bank_wdata),
      .rdata   (bank_rdata[w])
`ifdef CACHE_DATA_PARITY_EN
      ,
      .rparity (bank_rpar[w])
`endif
    );
  end

  // Read-side bookkeeping: which way/format the bank output belongs to,
  // and a copy of the last CPU read so ReadData holds between reads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid  <= 1'b0;
      rd_size   <= '0;
      rd_off    <= '0;
      sel_way   <= '0;
      hold_data <= '0;
    end else begin
      rd_valid <= cpu_rd;
      if (bank_re) sel_way <= tgt_way;
      if (cpu_rd) begin
        rd_size <= bus.in_Size;
        rd_off  <= bus.in_Offset[1:0];
      end
      if (rd_valid) hold_data <= fmt_rdata;
    end
  end

  assign sel_rdata = bank_rdata[sel_way];
  assign fmt_rdata = format_read(sel_rdata, rd_size, rd_off);

  assign bus.out_ReadData   = rd_valid ? fmt_rdata : hold_data;
  assign bus.out_ReadValid  = rd_valid;
  assign bus.out_Busy       = (state != ST_IDLE);
  assign bus.out_EvictData  = ev_valid ? sel_rdata : '0;
  assign bus.out_EvictValid = ev_valid;
  assign bus.out_LineDone   = done;

`ifdef CACHE_DATA_PARITY_EN
  logic [3:0] par_bad;
  assign par_bad = byte_parity(sel_rdata) ^ bank_rpar[sel_way];
  assign bus.out_ParityError = (rd_valid && |(par_bad & lane_mask(rd_size, rd_off))) ||
                               (ev_valid && |par_bad);
`endif

endmodule

// File: tb/tb_cache_data_array.sv
// Bench for cache_data_array: directed scenarios plus randomized CPU and
// line traffic checked against a per-word array model of the cache.
module tb_cache_data_array;

  localparam int WAYS  = 2;
  localparam int SETS  = 4;
  localparam int WORDS = 4;
  localparam int WAY_W = 1;
  localparam int IDX_W = 2;
  localparam int OFF_W = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cache_data_array_if #(
    .PARAM_WayNumber        (WAYS),
    .PARAM_SetNumber        (SETS),
    .PARAM_WordNumberInLine (WORDS)
  ) bus ();

  cache_data_array #(
    .PARAM_WayNumber        (WAYS),
    .PARAM_SetNumber        (SETS),
    .PARAM_WordNumberInLine (WORDS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model    [WAYS][SETS][WORDS];
  logic [31:0] fill_buf [WORDS];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_Req = 0; bus.in_RW = 0; bus.in_Size = 0; bus.in_Way = 0; bus.in_Index = 0;
    bus.in_Offset = 0; bus.in_WriteData = 0; bus.in_LineCmd = 0; bus.in_LineWay = 0;
    bus.in_LineIndex = 0; bus.in_FillData = 0; bus.in_FillValid = 0; bus.in_EvictReady = 0;
  endtask

  function automatic int shift_of(input int off, input int size);
    if (size == 0) return 8 * (off % 4);
    if (size == 1) return 16 * ((off / 2) % 2);
    return 0;
  endfunction

  function automatic logic [31:0] exp_read(input int way, input int idx, input int off, input int size);
    logic [31:0] w;
    w = model[way][idx][off / 4];
    if (size == 0) return ((w >> shift_of(off, 0)) & 32'hFF) * 32'h0101_0101;
    if (size == 1) return ((w >> shift_of(off, 1)) & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  task automatic model_write(input int way, input int idx, input int off, input int size,
                             input logic [31:0] data);
    logic [31:0] m;
    m = (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    m = m << shift_of(off, size);
    model[way][idx][off / 4] = (model[way][idx][off / 4] & ~m) | ((data << shift_of(off, size)) & m);
  endtask

  task automatic drive_cpu(input int rw, input int way, input int idx, input int off,
                           input int size, input logic [31:0] data);
    bus.in_Req = 1; bus.in_RW = 1'(rw); bus.in_Size = 2'(size); bus.in_Way = WAY_W'(way);
    bus.in_Index = IDX_W'(idx); bus.in_Offset = OFF_W'(off); bus.in_WriteData = data;
  endtask

  task automatic cpu_write(input int way, input int idx, input int off, input int size,
                           input logic [31:0] data);
    drive_cpu(0, way, idx, off, size, data);
    tick();
    bus.in_Req = 0;
    model_write(way, idx, off, size, data);
    check("wr_no_rvalid", 32'(bus.out_ReadValid), 0);
    check("wr_busy", 32'(bus.out_Busy), 0);
  endtask

  task automatic cpu_read(input int way, input int idx, input int off, input int size);
    logic [31:0] exp;
    exp = exp_read(way, idx, off, size);
    drive_cpu(1, way, idx, off, size, $urandom);
    tick();
    bus.in_Req = 0;
    check("rd_valid", 32'(bus.out_ReadValid), 1);
    check("rd_data", bus.out_ReadData, exp);
`ifdef CACHE_DATA_PARITY_EN
    check("rd_parity", 32'(bus.out_ParityError), 0);
`endif
    tick();
    check("rd_valid_pulse", 32'(bus.out_ReadValid), 0);
    check("rd_data_hold", bus.out_ReadData, exp);
  endtask

  // Random CPU request while a line op is running; it must be ignored.
  task automatic poke();
    drive_cpu(int'($urandom_range(0, 1)), int'($urandom_range(0, WAYS - 1)),
              int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, 4 * WORDS - 1)),
              int'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic line_fill(input int way, input int idx, input int gap_word, input int gap_n,
                           input bit rand_gaps);
    int gaps;
    bus.in_LineCmd = 2'b01; bus.in_LineWay = WAY_W'(way); bus.in_LineIndex = IDX_W'(idx);
    tick();
    bus.in_LineCmd = 2'b00;
    check("fill_busy_start", 32'(bus.out_Busy), 1);
    for (int k = 0; k < WORDS; k++) begin
      gaps = (k == gap_word) ? gap_n : (rand_gaps ? int'($urandom_range(0, 2)) : 0);
      repeat (gaps) begin
        bus.in_FillValid = 0;
        poke();
        tick();
        bus.in_Req = 0;
        check("fill_gap_busy", 32'(bus.out_Busy), 1);
        check("fill_gap_done", 32'(bus.out_LineDone), 0);
        check("fill_ignored_req", 32'(bus.out_ReadValid), 0);
      end
      bus.in_FillValid = 1; bus.in_FillData = fill_buf[k];
      tick();
      bus.in_FillValid = 0;
      model[way][idx][k] = fill_buf[k];
      check("fill_busy", 32'(bus.out_Busy), (k < WORDS - 1) ? 1 : 0);
      check("fill_done", 32'(bus.out_LineDone), (k < WORDS - 1) ? 0 : 1);
    end
    // CPU read presented in the LineDone cycle must be served.
    drive_cpu(1, way, idx, 0, 2, 0);
    tick();
    bus.in_Req = 0;
    check("done_cycle_rvalid", 32'(bus.out_ReadValid), 1);
    check("done_cycle_rdata", bus.out_ReadData, model[way][idx][0]);
    check("fill_done_pulse", 32'(bus.out_LineDone), 0);
  endtask

  task automatic line_evict(input int way, input int idx, input int stall_word, input int stall_n,
                            input bit rand_stalls);
    int stalls;
    bus.in_LineCmd = 2'b10; bus.in_LineWay = WAY_W'(way); bus.in_LineIndex = IDX_W'(idx);
    tick();
    bus.in_LineCmd = 2'b00;
    check("ev_busy_start", 32'(bus.out_Busy), 1);
    check("ev_valid_start", 32'(bus.out_EvictValid), 0);
    tick();
    for (int k = 0; k < WORDS; k++) begin
      check("ev_valid", 32'(bus.out_EvictValid), 1);
      check("ev_data", bus.out_EvictData, model[way][idx][k]);
`ifdef CACHE_DATA_PARITY_EN
      check("ev_parity", 32'(bus.out_ParityError), 0);
`endif
      stalls = (k == stall_word) ? stall_n : (rand_stalls ? int'($urandom_range(0, 2)) : 0);
      repeat (stalls) begin
        bus.in_EvictReady = 0;
        poke();
        tick();
        bus.in_Req = 0;
        check("ev_stall_valid", 32'(bus.out_EvictValid), 1);
        check("ev_stall_data", bus.out_EvictData, model[way][idx][k]);
        check("ev_ignored_req", 32'(bus.out_ReadValid), 0);
      end
      bus.in_EvictReady = 1;
      tick();
      bus.in_EvictReady = 0;
    end
    check("ev_valid_end", 32'(bus.out_EvictValid), 0);
    check("ev_done", 32'(bus.out_LineDone), 1);
    check("ev_busy_end", 32'(bus.out_Busy), 0);
    tick();
    check("ev_done_pulse", 32'(bus.out_LineDone), 0);
  endtask

  task automatic random_fill_buf();
    for (int k = 0; k < WORDS; k++) fill_buf[k] = $urandom;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    #1;
    check("rst_busy", 32'(bus.out_Busy), 0);
    check("rst_rvalid", 32'(bus.out_ReadValid), 0);
    check("rst_rdata", bus.out_ReadData, 0);
    check("rst_evalid", 32'(bus.out_EvictValid), 0);
    check("rst_edata", bus.out_EvictData, 0);
    check("rst_done", 32'(bus.out_LineDone), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1;
    tick();

    // Give every line known contents.
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        random_fill_buf();
        line_fill(w, s, -1, 0, 1'b1);
      end

    // Word then byte write/read.
    cpu_write(1, 2, 8, 2, 32'hDEAD_BEEF);
    cpu_read(1, 2, 8, 2);
    check("tp_word", bus.out_ReadData, 32'hDEAD_BEEF);
    cpu_write(1, 2, 9, 0, 32'h0000_005A);
    cpu_read(1, 2, 8, 2);
    check("tp_byte_merge", bus.out_ReadData, 32'hDEAD_5AEF);
    cpu_read(1, 2, 9, 0);
    check("tp_byte_repl", bus.out_ReadData, 32'h5A5A_5A5A);
    cpu_read(1, 2, 11, 1);

    // Fill with a 2-cycle gap after word 1, then evict with a stall on word 2.
    fill_buf[0] = 32'h1111_1111; fill_buf[1] = 32'h2222_2222;
    fill_buf[2] = 32'h3333_3333; fill_buf[3] = 32'h4444_4444;
    line_fill(0, 1, 1, 2, 1'b0);
    for (int o = 0; o < 16; o += 4) cpu_read(0, 1, o, 2);
    check("tp_fill_w3", bus.out_ReadData, 32'h4444_4444);
    line_evict(0, 1, 1, 3, 1'b0);
    cpu_read(1, 2, 8, 2);

    // Reset in the middle of a fill.
    bus.in_LineCmd = 2'b01; bus.in_LineWay = 0; bus.in_LineIndex = 2'd3;
    tick();
    bus.in_LineCmd = 0;
    for (int k = 0; k < 2; k++) begin
      bus.in_FillValid = 1; bus.in_FillData = 32'hA0A0_0000 + 32'(k);
      tick();
      model[0][3][k] = bus.in_FillData;
    end
    bus.in_FillValid = 0;
    #2 reset = 0;
    #1;
    check("mid_rst_busy", 32'(bus.out_Busy), 0);
    check("mid_rst_done", 32'(bus.out_LineDone), 0);
    check("mid_rst_rdata", bus.out_ReadData, 0);
    check("mid_rst_evalid", 32'(bus.out_EvictValid), 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1;
    tick();
    check("post_rst_done", 32'(bus.out_LineDone), 0);
    random_fill_buf();
    line_fill(0, 3, -1, 0, 1'b0);
    for (int o = 0; o < 16; o += 4) cpu_read(0, 3, o, 2);

    // CPU request and line command together: CPU wins.
    bus.in_LineCmd = 2'b01; bus.in_LineWay = 0; bus.in_LineIndex = 2'd2;
    drive_cpu(0, 0, 2, 4, 2, 32'hC0FF_EE00);
    tick();
    idle_inputs();
    model_write(0, 2, 4, 2, 32'hC0FF_EE00);
    check("tie_busy", 32'(bus.out_Busy), 0);
    tick();
    check("tie_busy_after", 32'(bus.out_Busy), 0);
    cpu_read(0, 2, 4, 2);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      int op, w, s, o, z;
      op = int'($urandom_range(0, 9));
      w  = int'($urandom_range(0, WAYS - 1));
      s  = int'($urandom_range(0, SETS - 1));
      o  = int'($urandom_range(0, 4 * WORDS - 1));
      z  = int'($urandom_range(0, 3));
      if (op < 4)       cpu_write(w, s, o, z, $urandom);
      else if (op < 8)  cpu_read(w, s, o, z);
      else if (op == 8) begin random_fill_buf(); line_fill(w, s, -1, 0, 1'b1); end
      else              line_evict(w, s, -1, 0, 1'b1);
    end

    // Final sweep of the whole array.
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++)
        line_evict(w, s, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
